// File: rtl/vec_pkg.sv
// vec_pkg: shared vector defaults and serializer state encoding.
package vec_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 4;
   typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/vec_serializer_if.sv
// vec_serializer_if: vector-in / lane-out handshake bundle.
interface vec_serializer_if #(parameter int WIDTH = 32, parameter int DEPTH = 4);
   localparam int IW = $clog2(DEPTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_vec [0:DEPTH-1];
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [IW-1:0]    out_idx;
   logic             out_last;
   modport master (output in_valid, in_vec, out_ready,
                   input  in_ready, out_valid, out_data, out_idx, out_last);
   modport slave  (input  in_valid, in_vec, out_ready,
                   output in_ready, out_valid, out_data, out_idx, out_last);
endinterface

// File: rtl/lane_counter.sv
// lane_counter: modulo-DEPTH lane index with enable, clear and last flag.
module lane_counter #(parameter int DEPTH = 4, localparam int IW = $clog2(DEPTH)) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          clr_i,
   output logic [IW-1:0] cnt_o,
   output logic          last_o
);
   logic [IW-1:0] cnt_q;
   assign cnt_o  = cnt_q;
   assign last_o = cnt_q == IW'(DEPTH - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (en_i) cnt_q <= last_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/vec_serializer.sv
// vec_serializer: captures a DEPTH-lane vector and emits it one lane per transfer.
module vec_serializer import vec_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input logic              clk,
   input logic              reset,
   vec_serializer_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);
   state_e           state_q;
   logic [WIDTH-1:0] buf_q [0:DEPTH-1];
   logic [IW-1:0]    cnt;
   logic             last, xfer, accept;
   assign xfer   = state_q == SEND && bus.out_ready;
   // Gate with reset so in_ready drops while reset is held, not just after.
   assign bus.in_ready = reset && (state_q == IDLE || (xfer && last));
   assign accept = bus.in_valid && bus.in_ready;
   lane_counter #(.DEPTH(DEPTH)) u_cnt (
      .clk    (clk),
      .rst_n  (reset),
      .en_i   (xfer && !last),
      .clr_i  (accept || (xfer && last)),
      .cnt_o  (cnt),
      .last_o (last)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         buf_q   <= '{default: '0};
      end else if (accept) begin
         state_q <= SEND;
         buf_q   <= bus.in_vec;
      end else if (xfer && last) state_q <= IDLE;
   assign bus.out_valid = state_q == SEND;
   assign bus.out_data  = bus.out_valid ? buf_q[cnt] : '0;
   assign bus.out_idx   = bus.out_valid ? cnt : '0;
   assign bus.out_last  = bus.out_valid && last;
endmodule

// File: tb/tb_vec_serializer.sv
// tb_vec_serializer: directed checks of reset, serialization, backpressure and back-to-back.
module tb_vec_serializer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;
   vec_serializer_if #(.WIDTH(32), .DEPTH(4)) bus ();
   vec_serializer #(.WIDTH(32), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic lane(input string tag, input int d, input int i, input bit l);
      chk({tag, " valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " data"}, 64'(bus.out_data), 64'(d));
      chk({tag, " idx"}, 64'(bus.out_idx), 64'(i));
      chk({tag, " last"}, 64'(bus.out_last), 64'(l));
   endtask
   task automatic idle_out(input string tag);
      chk({tag, " valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, " data"}, 64'(bus.out_data), 64'd0);
      chk({tag, " idx"}, 64'(bus.out_idx), 64'd0);
      chk({tag, " last"}, 64'(bus.out_last), 64'd0);
   endtask
   initial begin
      bus.in_valid  = 1'b1;
      bus.in_vec    = '{32'd1, 32'd2, 32'd3, 32'd4};
      bus.out_ready = 1'b1;
      #1;
      chk("rst in_ready", 64'(bus.in_ready), 64'd0);
      idle_out("rst");
      tick; tick;
      chk("rst hold in_ready", 64'(bus.in_ready), 64'd0);
      idle_out("rst hold");
      reset = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      chk("post rst in_ready", 64'(bus.in_ready), 64'd1);
      idle_out("post rst no capture");
      // Single vector, with in_vec scrambled right after accept
      bus.in_vec   = '{32'd4, 32'd5, 32'd6, 32'd7};
      bus.in_valid = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      bus.in_vec   = '{default: 32'hFF};
      #1;
      for (int i = 0; i < 4; i++) begin
         lane("single", 4 + i, i, i == 3);
         chk("single in_ready", 64'(bus.in_ready), 64'(i == 3));
         tick;
      end
      idle_out("single done");
      // Backpressure at lane 1
      bus.in_vec   = '{32'd4, 32'd5, 32'd6, 32'd7};
      bus.in_valid = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      #1;
      lane("bp l0", 4, 0, 0);
      tick;
      bus.out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         lane("bp stall", 5, 1, 0);
         chk("bp in_ready", 64'(bus.in_ready), 64'd0);
         tick;
      end
      bus.out_ready = 1'b1;
      #1;
      lane("bp l1", 5, 1, 0);
      tick;
      lane("bp l2", 6, 2, 0);
      tick;
      bus.out_ready = 1'b0;
      #1;
      chk("bp last stalled in_ready", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      #1;
      lane("bp l3", 7, 3, 1);
      chk("bp last in_ready", 64'(bus.in_ready), 64'd1);
      tick;
      idle_out("bp done");
      // Back-to-back vectors
      bus.in_vec   = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      bus.in_valid = 1'b1;
      tick;
      bus.in_vec = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      #1;
      for (int i = 0; i < 8; i++) begin
         lane("b2b", (i < 4 ? 32'hA0 : 32'hB0) + (i % 4), i % 4, (i % 4) == 3);
         tick;
         if (i == 3) bus.in_valid = 1'b0;
      end
      #1;
      idle_out("b2b done");
      // Reset mid-SEND
      bus.in_vec   = '{32'd8, 32'd9, 32'd10, 32'd11};
      bus.in_valid = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      #1;
      lane("mid l0", 8, 0, 0);
      tick;
      lane("mid l1", 9, 1, 0);
      #1;
      reset = 1'b0;
      #1;
      idle_out("mid rst async");
      chk("mid rst in_ready", 64'(bus.in_ready), 64'd0);
      tick;
      reset = 1'b1;
      #1;
      idle_out("mid released");
      tick;
      idle_out("mid released 2");
      tick;
      idle_out("mid released 3");
      bus.in_vec   = '{32'd1, 32'd2, 32'd3, 32'd4};
      bus.in_valid = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      #1;
      lane("new l0", 1, 0, 0);
      tick;
      lane("new l1", 2, 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vec_serializer.md
VEC_SERIALIZER -- requirements
Module: vec_serializer

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one vector lane.
REQ-002 Parameter DEPTH, default 4, number of lanes per vector; SHALL be >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 in_valid  input  1  upstream offers a vector on in_vec.
REQ-006 in_ready  output  1  block accepts in_vec this cycle.
REQ-007 in_vec  input  WIDTH x [0:DEPTH-1] unpacked array  vector to serialize.
REQ-008 out_valid  output  1  out_data holds a valid lane.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  WIDTH  current lane value.
REQ-011 out_idx  output  clog2(DEPTH)  index of current lane.
REQ-012 out_last  output  1  current lane is index DEPTH-1.

Function
REQ-013 Input handshake: vector accepted in a cycle where in_valid && in_ready are both 1 at the clock edge.
REQ-014 Output handshake: lane transferred in a cycle where out_valid && out_ready are both 1 at the clock edge.
REQ-015 FSM states: IDLE (no vector held), SEND (vector held, lanes pending).
REQ-016 IDLE: in_ready=1, out_valid=0; on input accept -> capture all DEPTH lanes into internal buffer, lane counter=0, go SEND.
REQ-017 SEND: out_valid=1, out_data=buffer[counter], out_idx=counter, out_last=(counter==DEPTH-1).
REQ-018 SEND, out transfer with out_last=0: counter increments by 1, stay SEND.
REQ-019 SEND, out transfer with out_last=1: if in_valid that cycle, capture new vector, counter=0, stay SEND (zero-bubble back-to-back); else go IDLE.
REQ-020 in_ready in SEND SHALL equal out_ready && out_last; in_ready SHALL be 0 in SEND otherwise.
REQ-021 SEND with out_ready=0: out_data, out_idx, out_last, out_valid held stable; buffer unchanged.
REQ-022 Latency: first lane valid on out_data the cycle after input accept; DEPTH lanes leave in DEPTH consecutive cycles when out_ready held 1.
REQ-023 Lanes emitted strictly in index order 0..DEPTH-1; no lane skipped or repeated.
REQ-024 Counter SHALL never exceed DEPTH-1; wrap to 0 only through REQ-019.
REQ-025 Buffer SHALL not change while in SEND except on REQ-019 capture; in_vec changes while not accepted are ignored.
REQ-026 out_data, out_idx, out_last SHALL be 0 when out_valid=0.

Reset
REQ-027 reset=0 SHALL immediately (no clock needed) force state IDLE, counter 0, buffer all lanes 0.
REQ-028 During reset: in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0.
REQ-029 Reset mid-SEND SHALL discard the held vector; no remaining lanes emitted after release.
REQ-030 First accept possible in the first rising edge after reset returns to 1.

Structure
REQ-031 Shared package vec_pkg SHALL hold WIDTH/DEPTH defaults and the state enum (IDLE, SEND); the same package also serves the vector-register blocks.
REQ-032 One sub-module lane_counter (modulo-DEPTH counter with enable, clear, last flag, async active-low reset) SHALL implement the lane index.
REQ-033 Buffer and FSM registers reside in vec_serializer; output lane selection is a combinational mux on the counter.

Verification
REQ-034 Reset: hold reset=0 with in_valid=1, in_vec={1,2,3,4} -> in_ready=0, out_valid=0, all outputs 0; no capture.
REQ-035 Single vector, out_ready=1: accept {4,5,6,7} -> next 4 cycles out_data 4,5,6,7, out_idx 0..3, out_last only on 7, then out_valid=0.
REQ-036 Backpressure: out_ready=0 for 3 cycles at idx 1 -> out_data stays 5, out_idx stays 1; resumes 6,7 when out_ready=1.
REQ-037 Back-to-back: in_valid held with {A0..A3} then {B0..B3}, out_ready=1 -> 8 contiguous valid cycles A0..A3,B0..B3, no bubble.
REQ-038 Reset mid-SEND: assert reset after lane 1 of {8,9,10,11} -> outputs 0 immediately; after release out_valid=0 until new accept.
REQ-039 in_vec changed to {0xFF..} during SEND of {4,5,6,7} -> emitted lanes remain 4,5,6,7.
